// File: rtl/time_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encoding, digit widths and load clamping.
package time_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int BCD_MAX = 9;
    localparam int TENS_W  = 3;
    localparam int ONES_W  = 4;

    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/time_countdown_timer_bcd_down_digit.sv
// One down-counting digit of the countdown chain; wraps 0 -> MAX and passes the borrow upward.
module bcd_down_digit #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             borrow_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             borrow_out
);

    assign borrow_out = borrow_in & (q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en && borrow_in) begin
            q <= (q == '0) ? WIDTH'(MAX) : q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_countdown_timer.sv
// MM:SS BCD countdown timer with IDLE/RUN/PAUSE/ALARM control.
// Optional TIME_COUNTDOWN_AUTORELOAD_EN: reload the last loaded value on expiry instead of alarming.
module time_countdown_timer
    import time_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5,
    parameter int ALARM_TICKS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [TENS_W-1:0] load_mt,
    input  logic [ONES_W-1:0] load_mo,
    input  logic [TENS_W-1:0] load_st,
    input  logic [ONES_W-1:0] load_so,
    input  logic              start,
    input  logic              stop,
    output logic [TENS_W-1:0] min_tens,
    output logic [ONES_W-1:0] min_ones,
    output logic [TENS_W-1:0] sec_tens,
    output logic [ONES_W-1:0] sec_ones,
    output logic              running,
    output logic              zero,
    output logic              done,
    output logic              alarm
);

    state_t state, next_state;

    logic [7:0]        alarm_cnt;
    logic              dec, count_is_one, load_digits, reload, digit_load;
    logic              b_so, b_st, b_mo;
    logic [TENS_W-1:0] clamp_mt, clamp_st, val_mt, val_st;
    logic [ONES_W-1:0] clamp_mo, clamp_so, val_mo, val_so;

    assign clamp_mt = TENS_W'(clamp_digit({1'b0, load_mt}, 4'(MIN_TENS_MAX)));
    assign clamp_mo = clamp_digit(load_mo, 4'(BCD_MAX));
    assign clamp_st = TENS_W'(clamp_digit({1'b0, load_st}, 4'(SEC_TENS_MAX)));
    assign clamp_so = clamp_digit(load_so, 4'(BCD_MAX));

    assign count_is_one = (min_tens == '0) && (min_ones == '0) &&
                          (sec_tens == '0) && (sec_ones == ONES_W'(1));

`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
    logic [TENS_W-1:0] shadow_mt, shadow_st;
    logic [ONES_W-1:0] shadow_mo, shadow_so;
    logic              shadow_nonzero;

    assign shadow_nonzero = |{shadow_mt, shadow_mo, shadow_st, shadow_so};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_mt <= '0;
            shadow_mo <= '0;
            shadow_st <= '0;
            shadow_so <= '0;
        end else if (load_digits) begin
            shadow_mt <= clamp_mt;
            shadow_mo <= clamp_mo;
            shadow_st <= clamp_st;
            shadow_so <= clamp_so;
        end
    end

    assign val_mt = reload ? shadow_mt : clamp_mt;
    assign val_mo = reload ? shadow_mo : clamp_mo;
    assign val_st = reload ? shadow_st : clamp_st;
    assign val_so = reload ? shadow_so : clamp_so;
`else
    assign val_mt = clamp_mt;
    assign val_mo = clamp_mo;
    assign val_st = clamp_st;
    assign val_so = clamp_so;
`endif

    always_comb begin
        next_state  = state;
        load_digits = 1'b0;
        reload      = 1'b0;
        dec         = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    load_digits = 1'b1;
                end else if (start && !zero) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = PAUSE;
                end else if (tick && !zero) begin
                    dec = 1'b1;
                    if (count_is_one) begin
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
                        if (shadow_nonzero) begin
                            reload = 1'b1;
                        end else begin
                            next_state = ALARM;
                        end
`else
                        next_state = ALARM;
`endif
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    load_digits = 1'b1;
                    next_state  = IDLE;
                end else if (start) begin
                    next_state = RUN;
                end
            end
            ALARM: begin
                if (load) begin
                    load_digits = 1'b1;
                    next_state  = IDLE;
                end else if (stop) begin
                    next_state = IDLE;
                end else if (tick && alarm_cnt == 8'(ALARM_TICKS - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign digit_load = load_digits | reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
            alarm   <= (next_state == ALARM);
            done    <= dec && count_is_one;
        end
    end

    // Counts expiry ticks only while alarming; cleared in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_cnt <= '0;
        end else if (state != ALARM) begin
            alarm_cnt <= '0;
        end else if (tick) begin
            alarm_cnt <= alarm_cnt + 8'd1;
        end
    end

    bcd_down_digit #(.WIDTH(ONES_W), .MAX(BCD_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .en(dec), .borrow_in(1'b1), .load(digit_load),
        .load_val(val_so), .q(sec_ones), .borrow_out(b_so)
    );

    bcd_down_digit #(.WIDTH(TENS_W), .MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .en(dec), .borrow_in(b_so), .load(digit_load),
        .load_val(val_st), .q(sec_tens), .borrow_out(b_st)
    );

    bcd_down_digit #(.WIDTH(ONES_W), .MAX(BCD_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .en(dec), .borrow_in(b_st), .load(digit_load),
        .load_val(val_mo), .q(min_ones), .borrow_out(b_mo)
    );

    // The top borrow out is only asserted when every digit is 0, so it doubles as zero.
    bcd_down_digit #(.WIDTH(TENS_W), .MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .en(dec), .borrow_in(b_mo), .load(digit_load),
        .load_val(val_mt), .q(min_tens), .borrow_out(zero)
    );

endmodule
